// File: rtl/knn_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote_pkg
// Purpose  : Shared types, constants and field-extract macros for the KNN
//            vote reader (knn_vote and knn_label_counter).
// Contents : state_t      - FSM state encoding (IDLE/SCAN/DONE)
//            entry_w()    - width of one packed list entry
//            cnt_w()      - width of a vote counter for N entries
//            empty_dist() - distance value marking an unused entry
//            KNN_ENTRY_DIST / KNN_ENTRY_LABEL - field extract of entry i
// Revision : 1.0 - initial release
// ============================================================================

// Entry i occupies bits [(DW+LW)*(i+1)-1 : (DW+LW)*i]; distance sits above
// the label.
`ifndef KNN_VOTE_FIELD_MACROS
`define KNN_VOTE_FIELD_MACROS
`define KNN_ENTRY_DIST(vec, i, DW, LW)  vec[((DW)+(LW))*(i) + (LW) +: (DW)]
`define KNN_ENTRY_LABEL(vec, i, DW, LW) vec[((DW)+(LW))*(i) +: (LW)]
`endif

package knn_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_LABEL       = 8;
  localparam int DEFAULT_N_NEIGHBOUR = 10;

  function automatic int entry_w(input int dw, input int lw);
    return dw + lw;
  endfunction

  // N+1 values (0..N votes) must be representable.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // All ones in the low dw bits: the neighbour list's reset value.
  function automatic logic [63:0] empty_dist(input int dw);
    return (64'd1 << dw) - 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/knn_label_counter.sv
`default_nettype none
// ============================================================================
// Module   : knn_label_counter
// Purpose  : Combinational count of non-empty snapshot entries whose label
//            equals sel_label. One comparator per entry, then a sum.
// Ports    : snapshot  in  packed neighbour list
//            sel_label in  label being counted
//            count     out number of matching non-empty entries
// Revision : 1.0 - initial release
// ============================================================================
module knn_label_counter
  import knn_vote_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int LABEL       = DEFAULT_LABEL,
  parameter int N_Neighbour = DEFAULT_N_NEIGHBOUR
) (
  input  logic [entry_w(DATA_W, LABEL)*N_Neighbour-1:0] snapshot,
  input  logic [LABEL-1:0]                              sel_label,
  output logic [cnt_w(N_Neighbour)-1:0]                 count
);

  localparam int CNT_W = cnt_w(N_Neighbour);
  localparam logic [DATA_W-1:0] EMPTY_DIST = '1;

  logic [N_Neighbour-1:0] match;

  generate
    for (genvar i = 0; i < N_Neighbour; i++) begin : g_match
      assign match[i] = (`KNN_ENTRY_DIST(snapshot, i, DATA_W, LABEL) != EMPTY_DIST) &&
                        (`KNN_ENTRY_LABEL(snapshot, i, DATA_W, LABEL) == sel_label);
    end
  endgenerate

  // CNT_W holds N, so the running sum cannot wrap.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_Neighbour; i++) begin
      count = count + CNT_W'(match[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote
// Purpose  : Majority-label vote over the KNN neighbour list. A start pulse
//            snapshots the list; one entry is scanned per cycle and the label
//            with most votes wins, ties going to the nearest entry.
// Ports    : clk, rst       clock, synchronous active-high reset
//            start          request to classify current list contents
//            Neighbour_info packed list, entry 0 = nearest
//            busy           scan in progress
//            done           one-cycle result-valid pulse
//            label_out      winning label (held until next result)
//            vote_count     votes for label_out
//            empty          snapshot held no valid entry
// Revision : 1.0 - initial release
// ============================================================================
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int LABEL       = DEFAULT_LABEL,
  parameter int N_Neighbour = DEFAULT_N_NEIGHBOUR
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [entry_w(DATA_W, LABEL)*N_Neighbour-1:0] Neighbour_info,
  output logic                                          busy,
  output logic                                          done,
  output logic [LABEL-1:0]                              label_out,
  output logic [cnt_w(N_Neighbour)-1:0]                 vote_count,
  output logic                                          empty
);

  localparam int ENTRY_W = entry_w(DATA_W, LABEL);
  localparam int CNT_W   = cnt_w(N_Neighbour);
  localparam int IDX_W   = (N_Neighbour > 1) ? $clog2(N_Neighbour) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_Neighbour - 1);
  localparam logic [DATA_W-1:0] EMPTY_DIST = '1;

  state_t                         state;
  logic [IDX_W-1:0]               index;
  logic [ENTRY_W*N_Neighbour-1:0] snapshot;
  logic [CNT_W-1:0]               best_count;
  logic [LABEL-1:0]               best_label;

  logic [DATA_W-1:0] cur_dist;
  logic [LABEL-1:0]  cur_label;
  logic [CNT_W-1:0]  cur_count;
  logic              cur_better;
  logic [CNT_W-1:0]  nxt_count;
  logic [LABEL-1:0]  nxt_label;
  logic              accept;

  // The DONE cycle is already IDLE-bound, so it accepts start as well.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Entry selected by the scan index.
  always_comb begin
    cur_dist  = '0;
    cur_label = '0;
    for (int i = 0; i < N_Neighbour; i++) begin
      if (index == IDX_W'(i)) begin
        cur_dist  = `KNN_ENTRY_DIST(snapshot, i, DATA_W, LABEL);
        cur_label = `KNN_ENTRY_LABEL(snapshot, i, DATA_W, LABEL);
      end
    end
  end

  knn_label_counter #(
    .DATA_W      (DATA_W),
    .LABEL       (LABEL),
    .N_Neighbour (N_Neighbour)
  ) u_counter (
    .snapshot  (snapshot),
    .sel_label (cur_label),
    .count     (cur_count)
  );

  // Strictly greater: on a tie the earlier (nearer) entry keeps the lead.
  assign cur_better = (cur_dist != EMPTY_DIST) && (cur_count > best_count);
  assign nxt_count  = cur_better ? cur_count : best_count;
  assign nxt_label  = cur_better ? cur_label : best_label;

  // Data-path capture only; contents are don't-care until a start.
  always_ff @(posedge clk) begin
    if (accept) begin
      snapshot <= Neighbour_info;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      index      <= '0;
      best_count <= '0;
      best_label <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      label_out  <= '0;
      vote_count <= '0;
      empty      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            best_count <= '0;
            best_label <= '0;
            index      <= '0;
            busy       <= 1'b1;
            state      <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          best_count <= nxt_count;
          best_label <= nxt_label;
          if (index == LAST_IDX) begin
            // Outputs take the post-update values of the final entry.
            index      <= '0;
            done       <= 1'b1;
            label_out  <= nxt_label;
            vote_count <= nxt_count;
            empty      <= (nxt_count == '0);
            state      <= ST_DONE;
          end else begin
            index <= index + 1'b1;
          end
        end

        ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            best_count <= '0;
            best_label <= '0;
            index      <= '0;
            state      <= ST_SCAN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_vote
// Purpose  : Self-checking bench for knn_vote. Expected results are computed
//            from the driven list and queued at start; a monitor pops and
//            compares them whenever done pulses, including the done cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_knn_vote;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int N  = 10;
  localparam int CW = $clog2(N + 1);
  localparam logic [DW-1:0] EMPTY = '1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [(DW+LW)*N-1:0]  nbr = '0;
  logic                  busy;
  logic                  done;
  logic [LW-1:0]         label_out;
  logic [CW-1:0]         vote_count;
  logic                  empty;

  always #5 clk = ~clk;

  knn_vote #(
    .DATA_W      (DW),
    .LABEL       (LW),
    .N_Neighbour (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .Neighbour_info (nbr),
    .busy           (busy),
    .done           (done),
    .label_out      (label_out),
    .vote_count     (vote_count),
    .empty          (empty)
  );

  typedef struct {
    logic [LW-1:0] label;
    int            count;
    logic          empty;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [LW-1:0] lab[N];
  logic [DW-1:0] dst[N];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: count every label, then the nearest entry holding a
  // maximal count names the winner.
  function automatic exp_t model(input int due);
    exp_t e;
    int   cnt[N];
    int   mx = 0;
    e.label = '0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      if (dst[i] != EMPTY) begin
        for (int j = 0; j < N; j++)
          if (dst[j] != EMPTY && lab[j] == lab[i]) cnt[i]++;
        if (cnt[i] > mx) mx = cnt[i];
      end
    end
    for (int i = N - 1; i >= 0; i--)
      if (dst[i] != EMPTY && mx > 0 && cnt[i] == mx) e.label = lab[i];
    e.count = mx;
    e.empty = (mx == 0);
    e.due   = due;
    return e;
  endfunction

  task automatic pack_list();
    for (int i = 0; i < N; i++) nbr[(DW+LW)*i +: (DW+LW)] = {dst[i], lab[i]};
  endtask

  task automatic near_dists();
    for (int i = 0; i < N; i++) dst[i] = 32'(i * 10 + 1);
  endtask

  // Called at a negedge: start is sampled at the next posedge and done is
  // expected eleven cycles after this one.
  task automatic issue_now(input bit expect_result);
    pack_list();
    start = 1'b1;
    if (expect_result) sb.push_back(model(cyc + N + 1));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue(input bit expect_result);
    @(negedge clk);
    issue_now(expect_result);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(mon_e.due));
        check("label_out", 32'(label_out), 32'(mon_e.label));
        check("vote_count", 32'(vote_count), 32'(mon_e.count));
        check("empty", 32'(empty), 32'(mon_e.empty));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_label", 32'(label_out), 32'd0);
    check("rst_votes", 32'(vote_count), 32'd0);
    check("rst_empty", 32'(empty), 32'd0);
    rst = 1'b0;

    // Clear majority: label 3 with four votes.
    lab = '{8'd3, 8'd5, 8'd3, 8'd7, 8'd3, 8'd5, 8'd1, 8'd3, 8'd2, 8'd5};
    near_dists();
    issue(1'b1);
    check("busy_scan", 32'(busy), 32'd1);
    drain();
    check("busy_idle", 32'(busy), 32'd0);

    // Tie resolved toward the nearest entry, then with entries 0/1 swapped.
    lab = '{8'd5, 8'd3, 8'd3, 8'd5, 8'd1, 8'd2, 8'd4, 8'd6, 8'd7, 8'd8};
    issue(1'b1);
    drain();
    lab = '{8'd3, 8'd5, 8'd3, 8'd5, 8'd1, 8'd2, 8'd4, 8'd6, 8'd7, 8'd8};
    issue(1'b1);
    drain();

    // Empty entries carry label 4 but must not vote.
    lab = '{8'd9, 8'd9, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4};
    for (int i = 3; i < N; i++) dst[i] = EMPTY;
    issue(1'b1);
    drain();

    // Every entry empty.
    for (int i = 0; i < N; i++) dst[i] = EMPTY;
    issue(1'b1);
    drain();

    // Start re-pulsed mid-scan with a different list: first snapshot wins.
    lab = '{8'd6, 8'd6, 8'd2, 8'd2, 8'd2, 8'd6, 8'd6, 8'd1, 8'd1, 8'd0};
    near_dists();
    issue(1'b1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) nbr[(DW+LW)*i +: LW] = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start in the done cycle is accepted; next done 11 cycles later.
    lab = '{8'd1, 8'd2, 8'd2, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0};
    issue(1'b1);
    begin
      int t = 0;
      while (done !== 1'b1 && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (done !== 1'b1) check("b2b_done_timeout", 32'(done), 32'd1);
    end
    lab = '{8'd4, 8'd4, 8'd8, 8'd8, 8'd8, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0};
    issue_now(1'b1);
    drain();

    // Reset mid-scan: abort with no done, then a normal run.
    issue(1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_label", 32'(label_out), 32'd0);
    check("abort_votes", 32'(vote_count), 32'd0);
    check("abort_empty", 32'(empty), 32'd0);
    repeat (15) @(negedge clk);
    lab = '{8'd2, 8'd9, 8'd9, 8'd2, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    issue(1'b1);
    drain();

    // Random lists with a small label alphabet and some empty slots.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        lab[i] = 8'($urandom_range(0, 3));
        dst[i] = ($urandom_range(0, 3) == 0) ? EMPTY : 32'($urandom_range(0, 1000));
      end
      issue(1'b1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
